// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types and constants for the AES job sequencer slice.
//            FSM state encoding, cipher direction constants, legal key widths
//            and a round-count helper (Nr) per key width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_KEY_EXP = 3'd2,
    ST_RUN     = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  localparam logic c_mode_enc = 1'b0;
  localparam logic c_mode_dec = 1'b1;

  localparam int c_key_w_128 = 128;
  localparam int c_key_w_192 = 192;
  localparam int c_key_w_256 = 256;

  function automatic bit key_w_legal(input int kw);
    return (kw == c_key_w_128) || (kw == c_key_w_192) || (kw == c_key_w_256);
  endfunction

  // Number of cipher rounds for a given key width.
  function automatic int nr_for_key_w(input int kw);
    if (kw == c_key_w_128) return 10;
    if (kw == c_key_w_192) return 12;
    return 14;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : aes_watchdog
// Purpose  : Cycle counter that flags expiry on the TMO_CYC-th enabled cycle
//            since the last clear.
// Ports    : clk, n_rst (async active-low), clr (restart count),
//            en (count this cycle), expired (this is cycle TMO_CYC).
// Revision : 1.0 - initial release
// ============================================================================
module aes_watchdog #(
  parameter int TMO_CYC = 1023
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int c_cw = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
  localparam logic [c_cw-1:0] c_last = c_cw'(TMO_CYC - 1);

  logic [c_cw-1:0] r_cnt;

  // Count starts at 0 on the first cycle of a visit, so the comparison
  // against TMO_CYC-1 fires on exactly the TMO_CYC-th cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  assign expired = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/aes_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_job_sequencer
// Purpose  : Multi-block AES job controller. Latches a job on start, resets
//            SRAM, runs key expansion, then processes blk_cnt blocks at
//            consecutive source/destination addresses. Supports abort and a
//            per-phase watchdog that terminates the job with err.
// Ports    : clk, n_rst           - clock, async active-low reset
//            start, abort         - job request (level) / cancel
//            mode, usr_key, usr_addr, usr_loc, blk_cnt - job descriptor
//            key_d, blk_d         - key-expansion / block done pulses
//            key, key_en, mem_clr - key-expansion interface
//            con_en, en_or_de, s_addr, loc, blk_idx - datapath interface
//            sram_n_rst           - SRAM reset (active-low)
//            busy, AES_done, err  - job status
// Revision : 1.0 - initial release
// ============================================================================
module aes_job_sequencer
  import aes_pkg::*;
#(
  parameter int KEY_W   = 128,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 1023
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [KEY_W-1:0]  usr_key,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [ADDR_W-1:0] usr_loc,
  input  logic [CNT_W-1:0]  blk_cnt,
  input  logic              key_d,
  input  logic              blk_d,
  output logic [KEY_W-1:0]  key,
  output logic              key_en,
  output logic              con_en,
  output logic              en_or_de,
  output logic [ADDR_W-1:0] s_addr,
  output logic [ADDR_W-1:0] loc,
  output logic              mem_clr,
  output logic              sram_n_rst,
  output logic              busy,
  output logic              AES_done,
  output logic              err,
  output logic [CNT_W-1:0]  blk_idx
);

  generate
    if (!key_w_legal(KEY_W)) begin : g_bad_key_w
      $error("aes_job_sequencer: KEY_W must be 128, 192 or 256");
    end
    if (TMO_CYC < 1) begin : g_bad_tmo
      $error("aes_job_sequencer: TMO_CYC must be >= 1");
    end
  endgenerate

  state_t             r_state;
  state_t             w_nxt_state;
  logic [CNT_W-1:0]   w_nxt_idx;
  logic [KEY_W-1:0]   r_key;
  logic               r_mode;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_dst;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_active;
  logic               w_wd_en;
  logic               w_wd_clr;
  logic               w_expired;

  assign w_active = (r_state == ST_RESET) || (r_state == ST_KEY_EXP) ||
                    (r_state == ST_RUN)   || (r_state == ST_NEXT);
  assign w_wd_en  = (r_state == ST_KEY_EXP) || (r_state == ST_RUN);
  // Any state change restarts the count, so each KEY_EXP / RUN visit gets
  // a full TMO_CYC budget (NEXT separates consecutive RUN visits).
  assign w_wd_clr = (w_nxt_state != r_state);

  aes_watchdog #(
    .TMO_CYC (TMO_CYC)
  ) u_watchdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_expired)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = blk_idx;
    case (r_state)
      ST_IDLE:    if (start) w_nxt_state = ST_RESET;
      ST_RESET:   w_nxt_state = (r_cnt == '0) ? ST_DONE : ST_KEY_EXP;
      ST_KEY_EXP: begin
        // Completion in the expiry cycle still counts as success.
        if (key_d) begin
          w_nxt_state = ST_RUN;
          w_nxt_idx   = '0;
        end else if (w_expired) begin
          w_nxt_state = ST_ERR;
        end
      end
      ST_RUN: begin
        if (blk_d) begin
          w_nxt_state = (blk_idx == (r_cnt - CNT_W'(1))) ? ST_DONE : ST_NEXT;
        end else if (w_expired) begin
          w_nxt_state = ST_ERR;
        end
      end
      ST_NEXT: begin
        w_nxt_state = ST_RUN;
        w_nxt_idx   = blk_idx + CNT_W'(1);
      end
      ST_DONE, ST_ERR: if (!start) w_nxt_state = ST_IDLE;
      default:    w_nxt_state = ST_IDLE;
    endcase
    if (abort && w_active) w_nxt_state = ST_IDLE;
    if (w_nxt_state == ST_IDLE) w_nxt_idx = '0;
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they belong to.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_key      <= '0;
      r_mode     <= c_mode_enc;
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      blk_idx    <= '0;
      key        <= '0;
      key_en     <= 1'b0;
      con_en     <= 1'b0;
      en_or_de   <= 1'b0;
      s_addr     <= '0;
      loc        <= '0;
      mem_clr    <= 1'b0;
      sram_n_rst <= 1'b1;
      busy       <= 1'b0;
      AES_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      blk_idx <= w_nxt_idx;
      if ((r_state == ST_IDLE) && start) begin
        r_key  <= usr_key;
        r_mode <= mode;
        r_src  <= usr_addr;
        r_dst  <= usr_loc;
        r_cnt  <= blk_cnt;
      end
      key        <= ((w_nxt_state == ST_KEY_EXP) || (w_nxt_state == ST_RUN) ||
                     (w_nxt_state == ST_NEXT)) ? r_key : '0;
      key_en     <= (w_nxt_state == ST_KEY_EXP);
      mem_clr    <= (w_nxt_state == ST_KEY_EXP) && (r_mode == c_mode_enc);
      con_en     <= (w_nxt_state == ST_RUN);
      en_or_de   <= (w_nxt_state == ST_RUN) && r_mode;
      s_addr     <= (w_nxt_state == ST_RUN) ? (r_src + ADDR_W'(w_nxt_idx)) : '0;
      loc        <= (w_nxt_state == ST_RUN) ? (r_dst + ADDR_W'(w_nxt_idx)) : '0;
      sram_n_rst <= (w_nxt_state != ST_RESET);
      busy       <= (w_nxt_state == ST_RESET) || (w_nxt_state == ST_KEY_EXP) ||
                    (w_nxt_state == ST_RUN)   || (w_nxt_state == ST_NEXT);
      AES_done   <= (w_nxt_state == ST_DONE) || (w_nxt_state == ST_ERR);
      err        <= (w_nxt_state == ST_ERR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_job_sequencer
// Purpose  : Directed self-checking bench for aes_job_sequencer
//            (KEY_W=256, ADDR_W=8, CNT_W=8, TMO_CYC=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_job_sequencer;

  localparam int KEY_W   = 256;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = 8;
  localparam int TMO_CYC = 16;

  localparam logic [255:0] c_k1 = 256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] c_k2 = 256'hdeadbeefcafef00d0123456789abcdef_f0e1d2c3b4a5968778695a4b3c2d1e0f;

  logic              clk;
  logic              n_rst;
  logic              start;
  logic              abort;
  logic              mode;
  logic [KEY_W-1:0]  usr_key;
  logic [ADDR_W-1:0] usr_addr;
  logic [ADDR_W-1:0] usr_loc;
  logic [CNT_W-1:0]  blk_cnt;
  logic              key_d;
  logic              blk_d;
  logic [KEY_W-1:0]  key;
  logic              key_en;
  logic              con_en;
  logic              en_or_de;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] loc;
  logic              mem_clr;
  logic              sram_n_rst;
  logic              busy;
  logic              AES_done;
  logic              err;
  logic [CNT_W-1:0]  blk_idx;

  int n_cmp = 0;
  int n_mis = 0;

  aes_job_sequencer #(
    .KEY_W   (KEY_W),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .usr_key    (usr_key),
    .usr_addr   (usr_addr),
    .usr_loc    (usr_loc),
    .blk_cnt    (blk_cnt),
    .key_d      (key_d),
    .blk_d      (blk_d),
    .key        (key),
    .key_en     (key_en),
    .con_en     (con_en),
    .en_or_de   (en_or_de),
    .s_addr     (s_addr),
    .loc        (loc),
    .mem_clr    (mem_clr),
    .sram_n_rst (sram_n_rst),
    .busy       (busy),
    .AES_done   (AES_done),
    .err        (err),
    .blk_idx    (blk_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_job(input logic m, input logic [255:0] k, input logic [7:0] a,
                         input logic [7:0] l, input logic [7:0] c);
    mode = m; usr_key = k; usr_addr = a; usr_loc = l; blk_cnt = c; start = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; usr_key = '0;
    usr_addr = '0; usr_loc = '0; blk_cnt = '0; key_d = 1'b0; blk_d = 1'b0;
    #12;
    chk("rst_sram_n_rst", sram_n_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_key_en", key_en, 0);
    chk("rst_done", AES_done, 0);
    n_rst = 1'b1;
    tick();

    // ---- encrypt, 3 blocks ------------------------------------------------
    new_job(1'b0, c_k1, 8'h10, 8'h80, 8'd3);
    tick();
    chk("enc_reset_sram", sram_n_rst, 0);
    chk("enc_reset_busy", busy, 1);
    chk("enc_reset_key_en", key_en, 0);
    usr_addr = 8'h55; usr_loc = 8'h66; usr_key = c_k2;  // must be ignored
    tick();
    chk("enc_kexp_key_en", key_en, 1);
    chk("enc_kexp_mem_clr", mem_clr, 1);
    chk("enc_kexp_key", key, c_k1);
    tick(); tick();
    key_d = 1'b1;
    tick();
    key_d = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk("enc_run_con_en", con_en, 1);
      chk("enc_run_s_addr", s_addr, 8'h10 + b);
      chk("enc_run_loc", loc, 8'h80 + b);
      chk("enc_run_idx", blk_idx, b);
      chk("enc_run_dir", en_or_de, 0);
      repeat (4) tick();
      blk_d = 1'b1;
      tick();
      blk_d = 1'b0;
      if (b < 2) begin
        chk("enc_next_gap", con_en, 0);
        tick();
      end
    end
    chk("enc_done", AES_done, 1);
    chk("enc_err", err, 0);
    chk("enc_done_busy", busy, 0);
    tick();
    chk("enc_done_hold", AES_done, 1);
    start = 1'b0;
    tick();
    chk("enc_idle_done", AES_done, 0);

    // ---- decrypt, 256-bit key, 1 block -----------------------------------
    new_job(1'b1, c_k2, 8'h20, 8'h40, 8'd1);
    tick(); tick();
    chk("dec_key_en", key_en, 1);
    chk("dec_key", key, c_k2);
    chk("dec_mem_clr", mem_clr, 0);
    key_d = 1'b1; tick(); key_d = 1'b0;
    chk("dec_dir", en_or_de, 1);
    chk("dec_run_mem_clr", mem_clr, 0);
    chk("dec_s_addr", s_addr, 8'h20);
    blk_d = 1'b1; tick(); blk_d = 1'b0;
    chk("dec_done", AES_done, 1);
    start = 1'b0; tick();

    // ---- address wrap ----------------------------------------------------
    new_job(1'b0, c_k1, 8'hFE, 8'hFF, 8'd4);
    tick(); tick();
    key_d = 1'b1; tick(); key_d = 1'b0;
    chk("wrap_s0", s_addr, 8'hFE); chk("wrap_i0", blk_idx, 0);
    blk_d = 1'b1; tick(); blk_d = 1'b0; tick();
    chk("wrap_s1", s_addr, 8'hFF); chk("wrap_i1", blk_idx, 1); chk("wrap_l1", loc, 8'h00);
    blk_d = 1'b1; tick(); blk_d = 1'b0; tick();
    chk("wrap_s2", s_addr, 8'h00); chk("wrap_i2", blk_idx, 2);
    blk_d = 1'b1; tick(); blk_d = 1'b0; tick();
    chk("wrap_s3", s_addr, 8'h01); chk("wrap_i3", blk_idx, 3);
    blk_d = 1'b1; tick(); blk_d = 1'b0;
    chk("wrap_done", AES_done, 1);
    start = 1'b0; tick();

    // ---- key-expansion timeout -------------------------------------------
    new_job(1'b0, c_k1, 8'h00, 8'h00, 8'd1);
    tick(); tick();                 // KEY_EXP cycle 1
    repeat (15) tick();             // KEY_EXP cycle 16
    chk("tmo_last_kexp", key_en, 1);
    chk("tmo_no_err_yet", err, 0);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_done", AES_done, 1);
    chk("tmo_busy", busy, 0);
    start = 1'b0; tick();
    chk("tmo_idle_err", err, 0);

    // ---- completion coincident with expiry wins --------------------------
    new_job(1'b0, c_k1, 8'h00, 8'h00, 8'd1);
    tick(); tick();
    repeat (15) tick();
    key_d = 1'b1; tick(); key_d = 1'b0;
    chk("coin_kexp_run", con_en, 1);
    chk("coin_kexp_err", err, 0);
    repeat (15) tick();
    chk("coin_run_still", con_en, 1);
    blk_d = 1'b1; tick(); blk_d = 1'b0;
    chk("coin_blk_done", AES_done, 1);
    chk("coin_blk_err", err, 0);
    start = 1'b0; tick();

    // ---- abort in RUN at block 2 -----------------------------------------
    new_job(1'b0, c_k1, 8'h30, 8'h90, 8'd3);
    tick(); tick();
    key_d = 1'b1; tick(); key_d = 1'b0;
    blk_d = 1'b1; tick(); blk_d = 1'b0; tick();
    blk_d = 1'b1; tick(); blk_d = 1'b0; tick();
    chk("abt_idx2", blk_idx, 2);
    chk("abt_s_addr", s_addr, 8'h32);
    abort = 1'b1; start = 1'b0;
    tick();
    abort = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_con_en", con_en, 0);
    chk("abt_s_addr0", s_addr, 0);
    chk("abt_idx0", blk_idx, 0);
    chk("abt_sram", sram_n_rst, 1);
    chk("abt_done", AES_done, 0);
    chk("abt_key", key, 0);
    tick();

    // ---- reset mid-RUN ---------------------------------------------------
    new_job(1'b1, c_k2, 8'h05, 8'h06, 8'd2);
    tick(); tick();
    key_d = 1'b1; tick(); key_d = 1'b0;
    chk("nrst_pre_run", con_en, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("nrst_con_en", con_en, 0);
    chk("nrst_sram", sram_n_rst, 1);
    chk("nrst_busy", busy, 0);
    chk("nrst_key", key, 0);
    start = 1'b0;
    #1 n_rst = 1'b1;
    tick();

    // ---- zero-block job --------------------------------------------------
    new_job(1'b0, c_k1, 8'h00, 8'h00, 8'd0);
    tick();
    chk("zero_reset_sram", sram_n_rst, 0);
    chk("zero_reset_key_en", key_en, 0);
    tick();
    chk("zero_done", AES_done, 1);
    chk("zero_key_en", key_en, 0);
    chk("zero_err", err, 0);
    start = 1'b0; tick();
    chk("zero_idle", AES_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
